// File: rtl/line_bridge_pkg.sv
// ---------------------------------------------------------------------------
// line_bridge_pkg
// Shared types and constants for the single-line write-back bridge that sits
// between the multicycle CPU memory port and the burst physical memory.
//   line_bridge_state_t : FSM encoding (IDLE, WB, FILL, RESP)
//   BEATS / BEAT_W      : burst geometry (4 x 64-bit beats per line)
//   LINE_W / TAG_LSB    : line width and first tag bit of a byte address
// ---------------------------------------------------------------------------
package line_bridge_pkg;

    localparam int BEATS   = 4;
    localparam int BEAT_W  = 64;
    localparam int LINE_W  = 256;
    localparam int TAG_LSB = 5;
    localparam int TAG_W   = 32 - TAG_LSB;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        RESP = 2'd3
    } line_bridge_state_t;

    // Line-aligned byte address for a tag.
    function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag);
        return {tag, {TAG_LSB{1'b0}}};
    endfunction

endpackage

// File: rtl/line_bridge_if.sv
// ---------------------------------------------------------------------------
// line_bridge_if
// CPU-side and physical-memory-side signals of the line bridge.
//   slave  : the bridge's view (CPU requests in, pmem requests out)
//   master : the environment's view (CPU + physical memory)
//
// Handshake semantics:
//   CPU side   - mem_read / mem_write are levels held by the requester until
//                it sees the single-cycle mem_resp pulse; mem_rdata is only
//                meaningful while mem_resp = 1.
//   pmem side  - pmem_read / pmem_write are levels held for a whole 4-beat
//                burst; each pmem_resp pulse accepts (write) or delivers
//                (read) exactly one beat. pmem_read and pmem_write are never
//                both high.
// ---------------------------------------------------------------------------
interface line_bridge_if;

    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [63:0] pmem_wdata;
    logic [63:0] pmem_rdata;
    logic        pmem_resp;

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_rdata, mem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_rdata, mem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/line_bridge_line_buffer.sv
// ---------------------------------------------------------------------------
// line_buffer
// Storage for the bridge's one line: data, tag, valid and dirty.
//   i_beat_we/idx/data    : write one 64-bit beat (refill)
//   i_word_we/idx/data/be : byte-enable merge into one 32-bit word; always
//                           marks the line dirty, even with no lanes enabled
//   i_set_tag/i_tag       : install a new tag and mark the line valid
//   i_clr_dirty           : line has been written back
//   o_word / o_beat       : combinational word and beat read muxes
//   o_tag/o_valid/o_dirty : line status
// ---------------------------------------------------------------------------
module line_buffer
    import line_bridge_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_beat_we,
    input  logic [1:0]        i_beat_idx,
    input  logic [BEAT_W-1:0] i_beat_data,
    input  logic              i_word_we,
    input  logic [2:0]        i_word_idx,
    input  logic [31:0]       i_word_data,
    input  logic [3:0]        i_word_be,
    input  logic              i_set_tag,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic              i_clr_dirty,
    output logic [31:0]       o_word,
    output logic [BEAT_W-1:0] o_beat,
    output logic [TAG_W-1:0]  o_tag,
    output logic              o_valid,
    output logic              o_dirty
);

    logic [LINE_W-1:0] r_line;
    logic [TAG_W-1:0]  r_tag;
    logic              r_valid;
    logic              r_dirty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line  <= '0;
            r_tag   <= '0;
            r_valid <= 1'b0;
            r_dirty <= 1'b0;
        end else begin
            if (i_beat_we)
                r_line[BEAT_W*int'(i_beat_idx) +: BEAT_W] <= i_beat_data;
            if (i_word_we) begin
                for (int b = 0; b < 4; b++)
                    if (i_word_be[b])
                        r_line[32*int'(i_word_idx) + 8*b +: 8] <= i_word_data[8*b +: 8];
                r_dirty <= 1'b1;
            end
            if (i_clr_dirty)
                r_dirty <= 1'b0;
            if (i_set_tag) begin
                r_tag   <= i_tag;
                r_valid <= 1'b1;
            end
        end
    end

    assign o_word  = r_line[32*int'(i_word_idx) +: 32];
    assign o_beat  = r_line[BEAT_W*int'(i_beat_idx) +: BEAT_W];
    assign o_tag   = r_tag;
    assign o_valid = r_valid;
    assign o_dirty = r_dirty;

endmodule

// File: rtl/line_bridge.sv
// ---------------------------------------------------------------------------
// line_bridge
// Single-line write-back buffer between the CPU memory port and a 4x64-bit
// burst physical memory. Hits complete one cycle after acceptance; misses
// write back a dirty line, refill, then respond.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : line_bridge_if.slave (CPU + pmem signals)
//   o_state    : current FSM state (debug)
//   o_valid    : line valid (debug)
//   o_dirty    : line dirty (debug)
//   o_cnt      : burst beat counter (debug)
// ---------------------------------------------------------------------------
module line_bridge
    import line_bridge_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    line_bridge_if.slave       bus,
    output line_bridge_state_t o_state,
    output logic               o_valid,
    output logic               o_dirty,
    output logic [1:0]         o_cnt
);

    line_bridge_state_t r_state, w_state_nxt;
    logic [1:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_req_addr;
    logic [31:0] r_req_wdata;
    logic [3:0]  r_req_be;
    logic        r_req_we;

    logic              w_latch;
    logic              w_beat_we, w_word_we, w_set_tag, w_clr_dirty;
    logic [31:0]       w_word_rd;
    logic [BEAT_W-1:0] w_beat_rd;
    logic [TAG_W-1:0]  w_tag;
    logic              w_valid, w_dirty;

    logic              w_mem_resp, w_pmem_read, w_pmem_write;
    logic [31:0]       w_mem_rdata, w_pmem_address;
    logic [BEAT_W-1:0] w_pmem_wdata;

    line_buffer u_line (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_beat_we   (w_beat_we),
        .i_beat_idx  (r_cnt),
        .i_beat_data (bus.pmem_rdata),
        .i_word_we   (w_word_we),
        .i_word_idx  (r_req_addr[4:2]),
        .i_word_data (r_req_wdata),
        .i_word_be   (r_req_be),
        .i_set_tag   (w_set_tag),
        .i_tag       (r_req_addr[31:TAG_LSB]),
        .i_clr_dirty (w_clr_dirty),
        .o_word      (w_word_rd),
        .o_beat      (w_beat_rd),
        .o_tag       (w_tag),
        .o_valid     (w_valid),
        .o_dirty     (w_dirty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= 2'd0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_req_be    <= '0;
            r_req_we    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch) begin
                r_req_addr  <= bus.mem_address;
                r_req_wdata <= bus.mem_wdata;
                r_req_be    <= bus.mem_byte_enable;
                // A simultaneous read+write is handled as a write.
                r_req_we    <= bus.mem_write;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_latch        = 1'b0;
        w_beat_we      = 1'b0;
        w_word_we      = 1'b0;
        w_set_tag      = 1'b0;
        w_clr_dirty    = 1'b0;
        w_mem_resp     = 1'b0;
        w_mem_rdata    = '0;
        w_pmem_read    = 1'b0;
        w_pmem_write   = 1'b0;
        w_pmem_address = '0;
        w_pmem_wdata   = '0;
        case (r_state)
            IDLE: begin
                if (bus.mem_read || bus.mem_write) begin
                    w_latch = 1'b1;
                    if (w_valid && (w_tag == bus.mem_address[31:TAG_LSB]))
                        w_state_nxt = RESP;
                    else if (w_dirty)
                        w_state_nxt = WB;
                    else
                        w_state_nxt = FILL;
                end
            end
            WB: begin
                w_pmem_write   = 1'b1;
                w_pmem_address = line_addr(w_tag);
                w_pmem_wdata   = w_beat_rd;
                if (bus.pmem_resp) begin
                    // Counter wraps to 0 on the last beat.
                    w_cnt_nxt = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_clr_dirty = 1'b1;
                        w_state_nxt = FILL;
                    end
                end
            end
            FILL: begin
                w_pmem_read    = 1'b1;
                w_pmem_address = line_addr(r_req_addr[31:TAG_LSB]);
                if (bus.pmem_resp) begin
                    w_beat_we = 1'b1;
                    w_cnt_nxt = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_set_tag   = 1'b1;
                        w_state_nxt = RESP;
                    end
                end
            end
            RESP: begin
                // Read data reflects the line before any write merge below.
                w_mem_resp  = 1'b1;
                w_mem_rdata = w_word_rd;
                w_word_we   = r_req_we;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.mem_resp     = w_mem_resp;
    assign bus.mem_rdata    = w_mem_rdata;
    assign bus.pmem_read    = w_pmem_read;
    assign bus.pmem_write   = w_pmem_write;
    assign bus.pmem_address = w_pmem_address;
    assign bus.pmem_wdata   = w_pmem_wdata;

    assign o_state = r_state;
    assign o_valid = w_valid;
    assign o_dirty = w_dirty;
    assign o_cnt   = r_cnt;

endmodule

// File: tb/tb_line_bridge.sv
// ---------------------------------------------------------------------------
// tb_line_bridge
// Directed bench for line_bridge: CPU requests, a physical-memory responder
// with optional beat gaps, a reference line model and expected-value queues.
// ---------------------------------------------------------------------------
module tb_line_bridge;
    import line_bridge_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    line_bridge_if bus ();

    line_bridge_state_t dbg_state;
    logic               dbg_valid;
    logic               dbg_dirty;
    logic [1:0]         dbg_cnt;

    line_bridge dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .o_state (dbg_state),
        .o_valid (dbg_valid),
        .o_dirty (dbg_dirty),
        .o_cnt   (dbg_cnt)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0]  exp_q[$];
    logic [63:0]  wb_q[$];
    logic [255:0] m_line;
    logic [63:0]  beat_buf[4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_word(input logic [255:0] ln, input logic [31:0] a);
        logic [2:0] w;
        w = a[4:2];
        return ln[32*int'(w) +: 32];
    endfunction

    function automatic logic [255:0] m_merge(input logic [255:0] ln, input logic [31:0] a,
                                             input logic [31:0] d, input logic [3:0] be);
        logic [2:0]   w;
        logic [255:0] r;
        w = a[4:2];
        r = ln;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[32*int'(w) + 8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Load the refill pattern into the responder and the reference line.
    task automatic load_beats(input logic [63:0] b0, input logic [63:0] b1,
                              input logic [63:0] b2, input logic [63:0] b3);
        beat_buf[0] = b0; beat_buf[1] = b1; beat_buf[2] = b2; beat_buf[3] = b3;
        m_line = {b3, b2, b1, b0};
    endtask

    task automatic queue_writeback();
        for (int i = 0; i < 4; i++) wb_q.push_back(m_line[64*i +: 64]);
    endtask

    // Drive a CPU request and record the expected response word.
    task automatic cpu_req(input logic we, input logic rd, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
        bus.mem_write       = we;
        bus.mem_read        = rd;
        bus.mem_address     = addr;
        bus.mem_wdata       = wdata;
        bus.mem_byte_enable = be;
        exp_q.push_back(m_word(m_line, addr));
        if (we) m_line = m_merge(m_line, addr, wdata, be);
    endtask

    task automatic cpu_drop();
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    task automatic wait_resp(input int exp_lat, input string tag);
        int lat = 0;
        logic [31:0] e;
        while (bus.mem_resp !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        if (bus.mem_resp === 1'b1) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            chk({tag, "_rdata"}, 64'(bus.mem_rdata), 64'(e));
            chk({tag, "_pmem_idle"}, {62'd0, bus.pmem_read, bus.pmem_write}, 64'd0);
        end
        cpu_drop();
        @(negedge clk);
        chk({tag, "_resp_pulse"}, 64'(bus.mem_resp), 64'd0);
        chk({tag, "_back_idle"}, 64'(dbg_state), 64'(IDLE));
    endtask

    // Serve one burst; abort_at >= 0 pulls reset just before that beat.
    task automatic serve_burst(input logic is_wb, input logic [31:0] exp_addr, input int gap,
                               input int start_lat, input int abort_at);
        int lat = 0;
        logic [63:0] e;
        while (((is_wb ? bus.pmem_write : bus.pmem_read) !== 1'b1) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk(is_wb ? "wb_start" : "fill_start", 64'(lat), 64'(start_lat));
        chk(is_wb ? "wb_addr" : "fill_addr", 64'(bus.pmem_address), 64'(exp_addr));
        for (int i = 0; i < 4; i++) begin
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_mem_resp", 64'(bus.mem_resp), 64'd0);
                chk("rst_mem_rdata", 64'(bus.mem_rdata), 64'd0);
                chk("rst_pmem_rw", {62'd0, bus.pmem_read, bus.pmem_write}, 64'd0);
                chk("rst_pmem_addr", 64'(bus.pmem_address), 64'd0);
                chk("rst_pmem_wdata", bus.pmem_wdata, 64'd0);
                chk("rst_state", 64'(dbg_state), 64'(IDLE));
                chk("rst_cnt", 64'(dbg_cnt), 64'd0);
                return;
            end
            for (int g = 0; g < gap; g++) begin
                chk("gap_cnt_hold", 64'(dbg_cnt), 64'(i));
                chk("gap_req_hold", 64'(is_wb ? bus.pmem_write : bus.pmem_read), 64'd1);
                chk("gap_addr_hold", 64'(bus.pmem_address), 64'(exp_addr));
                if (is_wb && wb_q.size() > 0) chk("gap_wdata_hold", bus.pmem_wdata, wb_q[0]);
                @(negedge clk);
            end
            if (is_wb) begin
                e = (wb_q.size() > 0) ? wb_q.pop_front() : 64'hxxxx_xxxx_xxxx_xxxx;
                chk("wb_beat", bus.pmem_wdata, e);
            end else begin
                bus.pmem_rdata = beat_buf[i];
            end
            bus.pmem_resp = 1'b1;
            @(negedge clk);
            bus.pmem_resp  = 1'b0;
            bus.pmem_rdata = '0;
        end
        chk(is_wb ? "wb_drop" : "fill_drop", 64'(is_wb ? bus.pmem_write : bus.pmem_read), 64'd0);
        chk("cnt_wrap", 64'(dbg_cnt), 64'd0);
    endtask

    // pmem_read and pmem_write must never overlap.
    always @(negedge clk) begin
        if (rst_n) begin
            vectors++;
            assert (!(bus.pmem_read === 1'b1 && bus.pmem_write === 1'b1)) else begin
                miscompares++;
                $error("FAIL pmem_overlap observed=11 expected=not_both");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_byte_enable = '0;
        bus.mem_address = '0; bus.mem_wdata = '0;
        bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;
        m_line = '0;

        // Reset state
        #2;
        chk("reset_mem_resp", 64'(bus.mem_resp), 64'd0);
        chk("reset_mem_rdata", 64'(bus.mem_rdata), 64'd0);
        chk("reset_pmem_rw", {62'd0, bus.pmem_read, bus.pmem_write}, 64'd0);
        chk("reset_pmem_addr", 64'(bus.pmem_address), 64'd0);
        chk("reset_pmem_wdata", bus.pmem_wdata, 64'd0);
        chk("reset_state", 64'(dbg_state), 64'(IDLE));
        chk("reset_valid_dirty", {62'd0, dbg_valid, dbg_dirty}, 64'd0);
        chk("reset_cnt", 64'(dbg_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean miss refill of 0x40
        load_beats(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                   64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
        cpu_req(1'b0, 1'b1, 32'h0000_0040, 32'h0, 4'h0);
        serve_burst(1'b0, 32'h0000_0040, 0, 1, -1);
        wait_resp(0, "rd40");
        chk("rd40_dirty", 64'(dbg_dirty), 64'd0);
        chk("rd40_valid", 64'(dbg_valid), 64'd1);

        // Hit
        cpu_req(1'b0, 1'b1, 32'h0000_0048, 32'h0, 4'h0);
        wait_resp(1, "hit48");

        // Partial write then read back
        cpu_req(1'b1, 1'b0, 32'h0000_0044, 32'hDEAD_BEEF, 4'b0011);
        wait_resp(1, "wr44");
        chk("wr44_dirty", 64'(dbg_dirty), 64'd1);
        cpu_req(1'b0, 1'b1, 32'h0000_0044, 32'h0, 4'h0);
        wait_resp(1, "rd44");

        // Dirty miss with 3-cycle gaps between beats
        queue_writeback();
        load_beats(64'hA0A0_0000_A0A0_0001, 64'hA1A1_0000_A1A1_0002,
                   64'hA2A2_0000_A2A2_0003, 64'hA3A3_0000_A3A3_0004);
        cpu_req(1'b0, 1'b1, 32'h0000_1000, 32'h0, 4'h0);
        serve_burst(1'b1, 32'h0000_0040, 3, 1, -1);
        chk("wb_clears_dirty", 64'(dbg_dirty), 64'd0);
        serve_burst(1'b0, 32'h0000_1000, 3, 0, -1);
        wait_resp(0, "rd1000");

        // Write with no byte lanes still marks dirty
        cpu_req(1'b1, 1'b0, 32'h0000_1004, 32'hFFFF_FFFF, 4'b0000);
        wait_resp(1, "wr1004_be0");
        chk("be0_dirty", 64'(dbg_dirty), 64'd1);
        cpu_req(1'b0, 1'b1, 32'h0000_1004, 32'h0, 4'h0);
        wait_resp(1, "rd1004");

        // Read and write together act as a write
        cpu_req(1'b1, 1'b1, 32'h0000_1018, 32'h1234_5678, 4'b1111);
        wait_resp(1, "rw1018");
        cpu_req(1'b0, 1'b1, 32'h0000_1018, 32'h0, 4'h0);
        wait_resp(1, "rd1018");

        // Reset during refill beat 2, then the same line misses again
        queue_writeback();
        load_beats(64'h5555_0000_5555_0001, 64'h6666_0000_6666_0002,
                   64'h7777_0000_7777_0003, 64'h8888_0000_8888_0004);
        cpu_req(1'b0, 1'b1, 32'h0000_200C, 32'h0, 4'h0);
        serve_burst(1'b1, 32'h0000_1000, 0, 1, -1);
        serve_burst(1'b0, 32'h0000_2000, 0, 0, 2);
        cpu_drop();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid_dirty", {62'd0, dbg_valid, dbg_dirty}, 64'd0);
        cpu_req(1'b0, 1'b1, 32'h0000_200C, 32'h0, 4'h0);
        serve_burst(1'b0, 32'h0000_2000, 1, 1, -1);
        wait_resp(0, "rd200c");

        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        chk("wb_q_drained", 64'(wb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
